// File: rtl/pipe_reg_de_if.sv
// rtl/pipe_reg_de_if.sv - D->E pipeline register bus: D-side inputs, forward sources, E-side outputs
//
// Purpose : groups every D-side, forwarding and E-side signal of the D->E
//           pipeline register so the register and its driver share one bundle.
// Signals :
//   stall_D, flush_E            hazard controls
//   instrD, pc8D, extD          D-stage instruction, PC+8, extended immediate
//   rd1D, rd2D                  regfile reads of rs / rt
//   fwd_rs_D, fwd_rt_D          forward selects (0 regfile, 1 E, 2 M, 3 W)
//   pc8E_fwd, aluoutM, resultW  forward sources for selects 1, 2, 3
//   instrE, pc8E, extE          E-stage instruction, PC+8, immediate
//   rsE_data, rtE_data          resolved operands in E
//   validE                      1 = real instruction, 0 = bubble
//   stall_cnt, flush_cnt        saturating bubble event counters
// Modports: master drives the D side and observes E; slave is the register.
interface pipe_reg_de_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             stall_D;
  logic             flush_E;
  logic [31:0]      instrD;
  logic [WIDTH-1:0] pc8D;
  logic [WIDTH-1:0] extD;
  logic [WIDTH-1:0] rd1D;
  logic [WIDTH-1:0] rd2D;
  logic [1:0]       fwd_rs_D;
  logic [1:0]       fwd_rt_D;
  logic [WIDTH-1:0] pc8E_fwd;
  logic [WIDTH-1:0] aluoutM;
  logic [WIDTH-1:0] resultW;
  logic [31:0]      instrE;
  logic [WIDTH-1:0] pc8E;
  logic [WIDTH-1:0] extE;
  logic [WIDTH-1:0] rsE_data;
  logic [WIDTH-1:0] rtE_data;
  logic             validE;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output stall_D, flush_E, instrD, pc8D, extD, rd1D, rd2D,
           fwd_rs_D, fwd_rt_D, pc8E_fwd, aluoutM, resultW,
    input  instrE, pc8E, extE, rsE_data, rtE_data, validE,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  stall_D, flush_E, instrD, pc8D, extD, rd1D, rd2D,
           fwd_rs_D, fwd_rt_D, pc8E_fwd, aluoutM, resultW,
    output instrE, pc8E, extE, rsE_data, rtE_data, validE,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_reg_de.sv
// rtl/pipe_reg_de.sv - D->E pipeline register with operand forwarding and bubble counters
//
// Purpose : resolves the D-stage rs/rt forward selects into operand values and
//           latches them with instrD, pc8D and extD into E. Inserts a NOP
//           bubble on flush_E or stall_D and counts those bubbles.
// Ports   :
//   clk    in  core clock, rising edge
//   reset  in  synchronous, active-high; overrides everything
//   bus    slave modport of pipe_reg_de_if (D side, forward sources, E side)
module pipe_reg_de #(
  parameter int          WIDTH = 32,
  parameter logic [31:0] NOP   = 32'h0,
  parameter int          CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  pipe_reg_de_if.slave bus
);

  logic [WIDTH-1:0] w_rs_val;
  logic [WIDTH-1:0] w_rt_val;

  logic [31:0]      r_instrE;
  logic [WIDTH-1:0] r_pc8E;
  logic [WIDTH-1:0] r_extE;
  logic [WIDTH-1:0] r_rsE;
  logic [WIDTH-1:0] r_rtE;
  logic             r_validE;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Forward mux. Register $0 is hard-wired zero, so a zero register field
  // wins over any select (a younger write to $0 must never be forwarded).
  always_comb begin
    w_rs_val = '0;
    w_rt_val = '0;
    if (bus.instrD[25:21] != 5'd0) begin
      case (bus.fwd_rs_D)
        2'd0:    w_rs_val = bus.rd1D;
        2'd1:    w_rs_val = bus.pc8E_fwd;
        2'd2:    w_rs_val = bus.aluoutM;
        default: w_rs_val = bus.resultW;
      endcase
    end
    if (bus.instrD[20:16] != 5'd0) begin
      case (bus.fwd_rt_D)
        2'd0:    w_rt_val = bus.rd2D;
        2'd1:    w_rt_val = bus.pc8E_fwd;
        2'd2:    w_rt_val = bus.aluoutM;
        default: w_rt_val = bus.resultW;
      endcase
    end
  end

  // Priority reset > flush > stall > load. A stall still sends a bubble into
  // E; the D stage holds its own values, so nothing is kept here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instrE    <= NOP;
      r_pc8E      <= '0;
      r_extE      <= '0;
      r_rsE       <= '0;
      r_rtE       <= '0;
      r_validE    <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (bus.flush_E || bus.stall_D) begin
      r_instrE <= NOP;
      r_pc8E   <= '0;
      r_extE   <= '0;
      r_rsE    <= '0;
      r_rtE    <= '0;
      r_validE <= 1'b0;
      // A simultaneous stall is attributed to the flush only.
      if (bus.flush_E) begin
        if (r_flush_cnt != {CNT_W{1'b1}})
          r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end else begin
        if (r_stall_cnt != {CNT_W{1'b1}})
          r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end else begin
      r_instrE <= bus.instrD;
      r_pc8E   <= bus.pc8D;
      r_extE   <= bus.extD;
      r_rsE    <= w_rs_val;
      r_rtE    <= w_rt_val;
      r_validE <= 1'b1;
    end
  end

  assign bus.instrE    = r_instrE;
  assign bus.pc8E      = r_pc8E;
  assign bus.extE      = r_extE;
  assign bus.rsE_data  = r_rsE;
  assign bus.rtE_data  = r_rtE;
  assign bus.validE    = r_validE;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_reg_de.sv
// tb/tb_pipe_reg_de.sv - scoreboard bench for pipe_reg_de (16-bit and 2-bit counter instances)
module tb_pipe_reg_de;

  typedef struct {
    bit          rst;
    bit          stall;
    bit          flush;
    logic [31:0] instr;
    logic [31:0] pc8;
    logic [31:0] ext;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [1:0]  frs;
    logic [1:0]  frt;
    logic [31:0] fe;
    logic [31:0] fm;
    logic [31:0] fw;
  } stim_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc8;
    logic [31:0] ext;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] valid;
    logic [31:0] scnt;
    logic [31:0] fcnt;
    logic [31:0] scnt2;
    logic [31:0] fcnt2;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_reg_de_if #(.WIDTH(32), .CNT_W(16)) ifm ();
  pipe_reg_de_if #(.WIDTH(32), .CNT_W(2))  ifs ();

  pipe_reg_de #(.WIDTH(32), .NOP(32'h0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(ifm)
  );
  pipe_reg_de #(.WIDTH(32), .NOP(32'h0), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(ifs)
  );

  assign ifs.stall_D  = ifm.stall_D;
  assign ifs.flush_E  = ifm.flush_E;
  assign ifs.instrD   = ifm.instrD;
  assign ifs.pc8D     = ifm.pc8D;
  assign ifs.extD     = ifm.extD;
  assign ifs.rd1D     = ifm.rd1D;
  assign ifs.rd2D     = ifm.rd2D;
  assign ifs.fwd_rs_D = ifm.fwd_rs_D;
  assign ifs.fwd_rt_D = ifm.fwd_rt_D;
  assign ifs.pc8E_fwd = ifm.pc8E_fwd;
  assign ifs.aluoutM  = ifm.aluoutM;
  assign ifs.resultW  = ifm.resultW;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   m_sc, m_fc, m_sc2, m_fc2;

  function automatic int sat_inc(int v, int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // Operand as the ISA defines it: register 0 reads zero, otherwise the
  // selected producer (regfile, E, M, W) supplies the value.
  function automatic logic [31:0] operand(logic [4:0] reg_no, logic [1:0] sel,
                                          logic [31:0] rf, stim_t s);
    logic [31:0] src [4];
    src[0] = rf; src[1] = s.fe; src[2] = s.fm; src[3] = s.fw;
    return (reg_no == 5'd0) ? 32'h0 : src[sel];
  endfunction

  function automatic stim_t mk(logic [31:0] instr);
    stim_t s;
    s.rst = 0; s.stall = 0; s.flush = 0;
    s.instr = instr; s.pc8 = $urandom; s.ext = $urandom;
    s.rd1 = $urandom; s.rd2 = $urandom; s.frs = 2'd0; s.frt = 2'd0;
    s.fe = $urandom; s.fm = $urandom; s.fw = $urandom;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    @(negedge clk);
    reset         = s.rst;
    ifm.stall_D   = s.stall;
    ifm.flush_E   = s.flush;
    ifm.instrD    = s.instr;
    ifm.pc8D      = s.pc8;
    ifm.extD      = s.ext;
    ifm.rd1D      = s.rd1;
    ifm.rd2D      = s.rd2;
    ifm.fwd_rs_D  = s.frs;
    ifm.fwd_rt_D  = s.frt;
    ifm.pc8E_fwd  = s.fe;
    ifm.aluoutM   = s.fm;
    ifm.resultW   = s.fw;
    e.instr = 0; e.pc8 = 0; e.ext = 0; e.rs = 0; e.rt = 0; e.valid = 0;
    if (s.rst) begin
      m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
    end else if (s.flush) begin
      m_fc  = sat_inc(m_fc, 65535);
      m_fc2 = sat_inc(m_fc2, 3);
    end else if (s.stall) begin
      m_sc  = sat_inc(m_sc, 65535);
      m_sc2 = sat_inc(m_sc2, 3);
    end else begin
      e.instr = s.instr; e.pc8 = s.pc8; e.ext = s.ext; e.valid = 1;
      e.rs = operand(s.instr[25:21], s.frs, s.rd1, s);
      e.rt = operand(s.instr[20:16], s.frt, s.rd2, s);
    end
    e.scnt = m_sc; e.fcnt = m_fc; e.scnt2 = m_sc2; e.fcnt2 = m_fc2;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (vector %0d)", name, act, exp, n_vec);
    end
  endtask

  // Monitor: the register presents a result every cycle, one edge after
  // the stimulus that produced it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        check("instrE",    ifm.instrE,          e.instr);
        check("pc8E",      ifm.pc8E,            e.pc8);
        check("extE",      ifm.extE,            e.ext);
        check("rsE_data",  ifm.rsE_data,        e.rs);
        check("rtE_data",  ifm.rtE_data,        e.rt);
        check("validE",    32'(ifm.validE),     e.valid);
        check("stall_cnt", 32'(ifm.stall_cnt),  e.scnt);
        check("flush_cnt", 32'(ifm.flush_cnt),  e.fcnt);
        check("stall_cnt2",32'(ifs.stall_cnt),  e.scnt2);
        check("flush_cnt2",32'(ifs.flush_cnt),  e.fcnt2);
        check("validE2",   32'(ifs.validE),     e.valid);
      end
    end
  end

  initial begin
    stim_t s;
    logic [31:0] w;
    m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;

    s = mk(32'h0); s.rst = 1;
    step(s); step(s);

    // addu $3,$1,$2: rs from M, rt from regfile
    s = mk(32'h00221821); s.frs = 2'd2; s.fm = 32'h55; s.frt = 2'd0; s.rd2 = 32'h7;
    step(s);

    // rt = 31 forwarded from the jal in E, then rt = 0 must read zero
    s = mk(32'h009F0000); s.frt = 2'd1; s.fe = 32'h3008;
    step(s);
    s = mk(32'h00800000); s.frt = 2'd3; s.fw = 32'hDEAD;
    step(s);

    // three stall cycles then the same instruction lands
    s = mk(32'h00431020); s.frs = 2'd3; s.frt = 2'd2;
    s.stall = 1;
    step(s); step(s); step(s);
    s.stall = 0;
    step(s);

    // stall and flush together count only as a flush
    s = mk(32'h12345678); s.stall = 1; s.flush = 1;
    step(s);

    // five flushes saturate the 2-bit counter at 3
    s = mk(32'h8C410004); s.flush = 1;
    for (int i = 0; i < 5; i++) step(s);

    // reset in the middle of a stall
    s = mk(32'h00221821); s.stall = 1;
    step(s);
    s.rst = 1;
    step(s);
    s.rst = 0; s.stall = 0;
    step(s);

    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      if ($urandom_range(0, 5) == 0) w[25:21] = 5'd0;
      if ($urandom_range(0, 5) == 0) w[20:16] = 5'd0;
      s = mk(w);
      s.frs   = 2'($urandom_range(0, 3));
      s.frt   = 2'($urandom_range(0, 3));
      s.stall = ($urandom_range(0, 4) == 0);
      s.flush = ($urandom_range(0, 7) == 0);
      s.rst   = ($urandom_range(0, 60) == 0);
      step(s);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d results never checked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
